// File: rtl/fir_seq_ctrl_if.sv
// fir_seq_ctrl_if: control, stream-handshake and RAM-port bundle of the FIR sequencer
interface fir_seq_ctrl_if #(
  parameter int pADDR_WIDTH = 12,
  parameter int pLEN_WIDTH  = 32
);
  logic                   ap_start;
  logic [pLEN_WIDTH-1:0]  data_length;
  logic                   ap_idle;
  logic                   ap_done;
  logic                   cfg_tap_req;
  logic                   cfg_tap_gnt;
  logic                   ss_tvalid;
  logic                   ss_tlast;
  logic                   ss_tready;
  logic                   sm_tready;
  logic                   sm_tvalid;
  logic                   sm_tlast;
  logic                   tap_EN;
  logic [pADDR_WIDTH-1:0] tap_A;
  logic                   data_EN;
  logic [3:0]             data_WE;
  logic [pADDR_WIDTH-1:0] data_A;
  logic                   data_sel_zero;
  logic                   mac_clr;
  logic                   mac_en;
  modport master (
    input  ap_start, data_length, cfg_tap_req, ss_tvalid, ss_tlast, sm_tready,
    output ap_idle, ap_done, cfg_tap_gnt, ss_tready, sm_tvalid, sm_tlast,
           tap_EN, tap_A, data_EN, data_WE, data_A, data_sel_zero, mac_clr, mac_en
  );
  modport slave (
    output ap_start, data_length, cfg_tap_req, ss_tvalid, ss_tlast, sm_tready,
    input  ap_idle, ap_done, cfg_tap_gnt, ss_tready, sm_tvalid, sm_tlast,
           tap_EN, tap_A, data_EN, data_WE, data_A, data_sel_zero, mac_clr, mac_en
  );
endinterface

// File: rtl/fir_seq_ctrl.sv
// fir_seq_ctrl: circular-buffer MAC sequencer for the 11-tap FIR; FIR_TLAST_CHECK_EN lets ss_tlast end a run early
module fir_seq_ctrl #(
  parameter int pADDR_WIDTH = 12,
  parameter int Tape_Num    = 11,
  parameter int pLEN_WIDTH  = 32
) (
  input logic           axis_clk,
  input logic           axis_rst,
  fir_seq_ctrl_if.master bus
);
  localparam int KW = $clog2(Tape_Num);
  localparam logic [KW-1:0] K_LAST = KW'(Tape_Num - 1);
  localparam logic [KW:0] TN = (KW+1)'(Tape_Num);
  typedef enum logic [2:0] {IDLE, CLEAR, WAIT_IN, MAC, DRAIN, OUT} state_t;
  state_t state, state_nx;
  logic [KW-1:0] k, head, rd_idx;
  logic [KW:0] wrap_idx;
  logic [pLEN_WIDTH-1:0] len, count, count_nx;
  logic is_last;
  function automatic logic [pADDR_WIDTH-1:0] baddr(input logic [KW-1:0] i);
    return {{(pADDR_WIDTH-KW-2){1'b0}}, i, 2'b00};
  endfunction
  assign count_nx = count + 1'b1;
  assign wrap_idx = {1'b0, head} + TN - {1'b0, k};
  assign rd_idx = head >= k ? head - k : wrap_idx[KW-1:0];
`ifdef FIR_TLAST_CHECK_EN
  logic last_q;
  assign is_last = (count_nx == len) || last_q;
  // remember whether the sample now in flight was flagged final by the source
  always_ff @(posedge axis_clk or posedge axis_rst)
    if (axis_rst) last_q <= 1'b0;
    else if (state == WAIT_IN && bus.ss_tvalid) last_q <= bus.ss_tlast;
`else
  logic unused_tlast;
  assign unused_tlast = bus.ss_tlast;
  assign is_last = count_nx == len;
`endif
  // state register
  always_ff @(posedge axis_clk or posedge axis_rst)
    if (axis_rst) state <= IDLE;
    else state <= state_nx;
  // run bookkeeping: schedule index, circular head, sample count, latched length, status flags
  always_ff @(posedge axis_clk or posedge axis_rst)
    if (axis_rst) begin
      k <= '0;
      head <= '0;
      count <= '0;
      len <= '0;
      bus.ap_idle <= 1'b1;
      bus.ap_done <= 1'b0;
      bus.cfg_tap_gnt <= 1'b0;
    end else begin
      k <= ((state == CLEAR || state == MAC) && k != K_LAST) ? k + 1'b1 : '0;
      bus.cfg_tap_gnt <= state_nx == IDLE && bus.cfg_tap_req;
      bus.ap_idle <= state_nx == IDLE;
      if (state != IDLE && state_nx == IDLE) bus.ap_done <= 1'b1;
      if (state == IDLE && bus.ap_start) begin
        len <= bus.data_length;
        head <= '0;
        count <= '0;
        bus.ap_done <= 1'b0;
      end
      if (state == OUT && bus.sm_tready) begin
        head <= head == K_LAST ? '0 : head + 1'b1;
        count <= count_nx;
      end
    end
  // next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = bus.ap_start ? CLEAR : IDLE;
      CLEAR:   if (k == K_LAST) state_nx = len == '0 ? IDLE : WAIT_IN;
      WAIT_IN: state_nx = bus.ss_tvalid ? MAC : WAIT_IN;
      MAC:     state_nx = k == K_LAST ? DRAIN : MAC;
      DRAIN:   state_nx = OUT;
      OUT:     if (bus.sm_tready) state_nx = is_last ? IDLE : WAIT_IN;
      default: state_nx = IDLE;
    endcase
  end
  // outputs: RAM ports lead the accumulator by one cycle to cover the read latency
  always_comb begin
    bus.ss_tready = state == WAIT_IN;
    bus.sm_tvalid = state == OUT;
    bus.sm_tlast = state == OUT && is_last;
    bus.tap_EN = state == MAC;
    bus.tap_A = state == MAC ? baddr(k) : '0;
    bus.data_sel_zero = state == CLEAR;
    bus.data_EN = state == CLEAR || state == MAC || (state == WAIT_IN && bus.ss_tvalid);
    bus.data_WE = (state == CLEAR || (state == WAIT_IN && bus.ss_tvalid)) ? 4'hF : 4'h0;
    bus.data_A = state == CLEAR ? baddr(k) : state == WAIT_IN ? baddr(head) : state == MAC ? baddr(rd_idx) : '0;
    bus.mac_clr = state == MAC && k == KW'(1);
    bus.mac_en = (state == MAC && k > KW'(1)) || state == DRAIN;
  end
endmodule

// File: tb/tb_fir_seq_ctrl.sv
// tb_fir_seq_ctrl: scoreboard bench driving the sequencer through a behavioural RAM/MAC datapath
module tb_fir_seq_ctrl;
  logic clk = 1'b0, rst = 1'b1;
  logic signed [31:0] ss_tdata = '0;
  typedef struct {logic signed [31:0] y; logic last;} exp_t;
  exp_t sb[$];
  exp_t mon_e;
  int tests = 0, fails = 0, n_out = 0;
  int h[16] = '{0, -10, -9, 23, 56, 63, 56, 23, -9, -10, 0, 0, 0, 0, 0, 0};
  int xs[600];
  logic signed [31:0] data_ram[16] = '{default: 32'sd999};
  logic signed [31:0] tap_q = '0, data_q = '0, acc = '0;
  fir_seq_ctrl_if bus();
  fir_seq_ctrl dut (.axis_clk(clk), .axis_rst(rst), .bus(bus));
  always #5 clk = ~clk;
  // datapath model: 1-cycle-latency tap/data RAMs feeding the accumulator
  always @(posedge clk) begin
    if (bus.tap_EN) tap_q <= h[bus.tap_A[5:2]];
    if (bus.data_EN) begin
      data_q <= data_ram[bus.data_A[5:2]];
      if (bus.data_WE == 4'hF) data_ram[bus.data_A[5:2]] <= bus.data_sel_zero ? 32'sd0 : ss_tdata;
    end
    if (bus.mac_clr) acc <= tap_q * data_q;
    else if (bus.mac_en) acc <= acc + tap_q * data_q;
  end
  task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask
  // monitor: pop and compare on every output handshake
  always @(negedge clk) if (!rst) begin
    if (bus.ss_tready && bus.sm_tvalid) begin
      fails++;
      $display("FAIL ready_overlap: ss_tready=1 while sm_tvalid=1");
    end
    if (bus.sm_tvalid && bus.sm_tready) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_output: got y=%0d, expected no output", acc);
      end else begin
        mon_e = sb.pop_front();
        chk("y", acc, mon_e.y);
        chk("sm_tlast", bus.sm_tlast, mon_e.last);
      end
      n_out++;
    end
  end
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic push_exp(input int y, input logic last);
    exp_t e;
    e.y = y;
    e.last = last;
    sb.push_back(e);
  endtask
  task automatic send(input int v, input logic last);
    int t = 0;
    ss_tdata = v;
    bus.ss_tvalid = 1'b1;
    bus.ss_tlast = last;
    @(negedge clk);
    while (!bus.ss_tready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!bus.ss_tready) begin
      tests++;
      fails++;
      $display("FAIL ss_tready_timeout: got 0, expected 1 within 200 cycles");
    end
    @(posedge clk);
    #1;
    bus.ss_tvalid = 1'b0;
    bus.ss_tlast = 1'b0;
  endtask
  task automatic start_run(input int len);
    n_out = 0;
    bus.data_length = len;
    bus.ap_start = 1'b1;
    cyc(1);
    bus.ap_start = 1'b0;
  endtask
  task automatic wait_out(input int target);
    int t = 0;
    while (n_out < target && t < 2000) begin
      @(posedge clk);
      t++;
    end
    #1;
    if (n_out < target) begin
      tests++;
      fails++;
      $display("FAIL output_timeout: got %0d outputs, expected %0d", n_out, target);
    end
  endtask
  function automatic int yref(input int n);
    int s = 0;
    for (int k = 0; k < 11; k++) if (n >= k) s += h[k] * xs[n - k];
    return s;
  endfunction
  initial begin
    int nsend, t;
    bus.ap_start = 0;
    bus.data_length = 0;
    bus.cfg_tap_req = 0;
    bus.ss_tvalid = 0;
    bus.ss_tlast = 0;
    bus.sm_tready = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ap_idle", bus.ap_idle, 1);
    chk("rst_ap_done", bus.ap_done, 0);
    chk("rst_ss_tready", bus.ss_tready, 0);
    chk("rst_sm_tvalid", bus.sm_tvalid, 0);
    chk("rst_data_WE", bus.data_WE, 0);
    chk("rst_cfg_tap_gnt", bus.cfg_tap_gnt, 0);
    chk("rst_mac", {bus.mac_clr, bus.mac_en, bus.tap_EN, bus.data_EN}, 0);
    @(posedge clk);
    #1;
    rst = 0;
    bus.cfg_tap_req = 1;
    cyc(1);
    chk("gnt_idle", bus.cfg_tap_gnt, 1);
    start_run(600);
    chk("gnt_after_start", bus.cfg_tap_gnt, 0);
    chk("ap_idle_run", bus.ap_idle, 0);
    chk("ap_done_run", bus.ap_done, 0);
    bus.cfg_tap_req = 0;
    for (int i = 0; i < 11; i++) begin
      chk("clr_WE", bus.data_WE, 4'hF);
      chk("clr_A", bus.data_A, 4 * i);
      chk("clr_zero", bus.data_sel_zero, 1);
      cyc(1);
    end
    chk("wait_in_ready", bus.ss_tready, 1);
    for (int n = 0; n < 600; n++) begin
      xs[n] = ((n % 20 < 10) ? n % 20 : 20 - n % 20) * 7 - 30;
      push_exp(yref(n), n == 599);
      send(xs[n], 1'b0);
      if (n == 3) begin
        for (int k = 0; k < 11; k++) begin
          @(negedge clk);
          chk("mac_tap_A", bus.tap_A, 4 * k);
          chk("mac_data_A", bus.data_A, 4 * ((3 - k + 11) % 11));
        end
        cyc(1);
      end
    end
    wait_out(600);
    chk("run1_ap_done", bus.ap_done, 1);
    chk("run1_ap_idle", bus.ap_idle, 1);
    chk("run1_sb_empty", sb.size(), 0);
    bus.sm_tready = 0;
    start_run(3);
    chk("run2_ap_done_clr", bus.ap_done, 0);
    cyc(11);
    push_exp(0, 0);
    send(100, 0);
    t = 0;
    while (!bus.sm_tvalid && t < 100) begin
      cyc(1);
      t++;
    end
    chk("stall_reach_out", bus.sm_tvalid, 1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("stall_tvalid", bus.sm_tvalid, 1);
      chk("stall_ss_tready", bus.ss_tready, 0);
    end
    cyc(1);
    bus.sm_tready = 1;
    push_exp(-1000, 0);
    send(-7, 0);
    push_exp(-830, 1);
    send(50, 0);
    wait_out(3);
    chk("run2_ap_done", bus.ap_done, 1);
    chk("run2_ap_idle", bus.ap_idle, 1);
    start_run(0);
    for (int i = 0; i < 11; i++) begin
      chk("len0_ss_tready", bus.ss_tready, 0);
      cyc(1);
    end
    chk("len0_ap_done", bus.ap_done, 1);
    chk("len0_ap_idle", bus.ap_idle, 1);
    chk("len0_no_output", n_out, 0);
    start_run(10);
    cyc(11);
`ifdef FIR_TLAST_CHECK_EN
    nsend = 6;
`else
    nsend = 10;
`endif
    for (int n = 0; n < nsend; n++) begin
      xs[n] = n * 13 - 40;
      push_exp(yref(n), n == nsend - 1);
      send(xs[n], n == 5);
    end
    wait_out(nsend);
    cyc(2);
    chk("tlast_run_outputs", n_out, nsend);
    chk("tlast_ap_done", bus.ap_done, 1);
    chk("tlast_ap_idle", bus.ap_idle, 1);
    chk("final_sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fir_seq_ctrl.md
# fir_seq_ctrl

Sequencing controller for the 11-tap FIR engine. It owns the ap_start/ap_done/ap_idle protocol and the AXI-Stream input and output handshakes. It generates per-cycle tap-RAM and data-RAM (bram11, 1-cycle read latency) addresses for a circular-buffer MAC schedule, and drives the accumulator controls of the FIR datapath. It also grants the tap RAM to the AXI-Lite configuration path only while the engine is idle.

## Interface
- pADDR_WIDTH, 12, width of RAM byte addresses
- Tape_Num, 11, number of taps and data-RAM words
- pLEN_WIDTH, 32, width of data_length

- axis_clk  in  1  clock, all state on rising edge
- axis_rst  in  1  asynchronous, active-high reset
- ap_start  in  1  start pulse from config register 0x00 bit 0
- data_length  in  pLEN_WIDTH  samples per run (register 0x10), sampled on start
- ap_idle  out  1  engine idle (register 0x00 bit 2)
- ap_done  out  1  run complete (register 0x00 bit 1)
- cfg_tap_req  in  1  AXI-Lite path requests tap RAM
- cfg_tap_gnt  out  1  tap RAM granted to AXI-Lite
- ss_tvalid  in  1  input sample valid
- ss_tlast  in  1  input last flag
- ss_tready  out  1  controller accepts sample
- sm_tready  in  1  downstream ready
- sm_tvalid  out  1  output sample valid
- sm_tlast  out  1  output last flag
- tap_EN  out  1  tap RAM enable
- tap_A  out  pADDR_WIDTH  tap RAM byte address (4*k)
- data_EN  out  1  data RAM enable
- data_WE  out  4  data RAM byte write enables
- data_A  out  pADDR_WIDTH  data RAM byte address (4*index)
- data_sel_zero  out  1  datapath drives 0 on data_Di (clear); else ss_tdata
- mac_clr  out  1  accumulator loads product (first term)
- mac_en  out  1  accumulator adds product

## Operation
- Reset values: state IDLE, ap_idle=1, ap_done=0, cfg_tap_gnt=0, ss_tready=0, sm_tvalid=0, sm_tlast=0, all RAM enables and WE=0, mac_clr=mac_en=0, head=0, count=0.
- States: IDLE, CLEAR, WAIT_IN, MAC, DRAIN, OUT.
- IDLE: cfg_tap_gnt=cfg_tap_req. ap_start=1 → latch data_length, clear ap_done, ap_idle=0, go to CLEAR. ap_start wins over a same-cycle cfg_tap_req; cfg_tap_gnt drops the next cycle.
- CLEAR: Tape_Num cycles, data_WE=4'hF, data_sel_zero=1, data_A=4*i for i=0..Tape_Num-1. Then go to WAIT_IN, or go straight to IDLE with ap_done=1 if the latched length is 0.
- WAIT_IN: ss_tready=1. On ss_tvalid: data_WE=4'hF, data_A=4*head, go to MAC.
- MAC: k=0..Tape_Num-1, one per cycle. tap_A=4*k. data_A=4*((head-k) mod Tape_Num), wrapping from 0 to Tape_Num-1.
- Read latency is one cycle. mac_clr is high the cycle after k=0 is issued; mac_en is high on the following Tape_Num-1 cycles, the last of which is DRAIN.
- DRAIN: one cycle, then go to OUT.
- OUT: sm_tvalid=1 until sm_tready. On handshake: head=(head+1) mod Tape_Num, count+1. If count+1 == length, go to IDLE with ap_done=1 and ap_idle=1. Otherwise go to WAIT_IN.
- sm_tlast=1 in OUT when count+1 == length.
- ap_done stays 1 until the next accepted ap_start. ap_start outside IDLE is ignored.
- Reset mid-run aborts immediately to reset values. RAM contents are untouched.

## Timing
- Input handshake edge E0 → MAC occupies the cycles after E0..E10 → DRAIN → sm_tvalid=1 from edge E12 onward.
- Minimum sample period is 14 cycles: 1 WAIT_IN + 11 MAC + 1 DRAIN + 1 OUT.
- ss_tready is high only in WAIT_IN. It is never high while sm_tvalid=1.
- sm_tvalid, once high, holds with stable sm_tlast until sm_tready is sampled high.
- ap_idle and ap_done are registered. They update on the edge after the final output handshake.

## Configuration
- FIR_TLAST_CHECK_EN defined: in WAIT_IN, ss_tlast=1 on a handshake marks the current sample final. Its output carries sm_tlast=1, and the run ends with ap_done=1 even if count+1 < length.
- FIR_TLAST_CHECK_EN undefined: ss_tlast is ignored. Termination and sm_tlast come from count only.

## Test plan
- Reset with axis_rst held 3 cycles → ap_idle=1, ap_done=0, ss_tready=0, sm_tvalid=0, all WE=0.
- IDLE with cfg_tap_req=1 → cfg_tap_gnt=1. Then ap_start → cfg_tap_gnt=0 next cycle, 11 CLEAR writes to data_A 0x00..0x28.
- data_length=600, coefficients {0,-10,-9,23,56,63,56,23,-9,-10,0}, triangular wave, sm_tready=1 → 600 outputs match golden, sm_tlast only on output 599, then ap_done=1 and ap_idle=1.
- Fourth sample (head=3) → data_A sequence 0x0C,0x08,0x04,0x00,0x28,0x24,...,0x10 against tap_A 0x00..0x28.
- sm_tready held 0 for 20 cycles during OUT → sm_tvalid stays 1, ss_tready stays 0, no sample lost; data_length=0 → ap_done=1 after CLEAR with no stream traffic.
- With FIR_TLAST_CHECK_EN, data_length=10, ss_tlast on sample 5 → output 5 has sm_tlast=1 and ap_done=1 follows. Without the macro, the same run completes all 10 outputs.
